tcb_lib_byteena2logsize: RTL and testbench

Converts a byte-enable mode TCB manager into a logarithmic-size mode TCB subordinate access. A byte-enable mask that is not one naturally aligned power-of-two block is split into a sequence of aligned log-size transfers. Read bytes from those transfers are reassembled into a single subordinate response. The block sits between a byte-enable manager (CPU store/load unit, DMA) and a log-size-only peripheral or memory controller. Little-endian, single outstanding split, fixed response delay.

---
 rtl/tcb_lib_byteena2logsize.sv | 168 ++++++++++++++++
 tb/tb_tcb_lib_byteena2logsize.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tcb_lib_byteena2logsize.sv
// Byte-enable to log-size TCB adapter: splits an arbitrary byte-enable mask into
// naturally aligned power-of-two chunks and reassembles the read response.
module tcb_lib_byteena2logsize #(
  parameter  int DAT = 32,
  parameter  int ADR = 32,
  parameter  int DLY = 1,
  localparam int BEN = DAT/8,
  localparam int MAX = $clog2(BEN),
  localparam int SIZ = $clog2(MAX+1)
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           sub_vld,
  output logic           sub_rdy,
  input  logic           sub_wen,
  input  logic [ADR-1:0] sub_adr,
  input  logic [BEN-1:0] sub_ben,
  input  logic [DAT-1:0] sub_wdt,
  output logic [DAT-1:0] sub_rdt,
  output logic           sub_err,
  output logic           man_vld,
  input  logic           man_rdy,
  output logic           man_wen,
  output logic [ADR-1:0] man_adr,
  output logic [SIZ-1:0] man_siz,
  output logic [DAT-1:0] man_wdt,
  input  logic [DAT-1:0] man_rdt,
  input  logic           man_err
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SPLIT = 1'b1;

  function automatic logic [MAX-1:0] low_idx(input logic [BEN-1:0] m);
    logic [MAX-1:0] idx;
    idx = '0;
    for (int i = BEN-1; i >= 0; i--) if (m[i]) idx = MAX'(i);
    return idx;
  endfunction

  function automatic logic [BEN-1:0] lane_mask(input logic [MAX-1:0] o, input logic [SIZ-1:0] s);
    logic [BEN-1:0] ones;
    ones = '0;
    for (int i = 0; i < BEN; i++) if (i < (1 << s)) ones[i] = 1'b1;
    return ones << o;
  endfunction

  // Largest aligned block starting at the lowest enabled lane that is fully enabled.
  function automatic logic [SIZ-1:0] chunk_siz(input logic [BEN-1:0] m, input logic [MAX-1:0] o);
    logic [SIZ-1:0] best;
    logic [BEN-1:0] mk;
    best = '0;
    for (int s = 0; s <= MAX; s++) begin
      mk = lane_mask(o, SIZ'(s));
      if (((int'(o) & ((1 << s) - 1)) == 0) && ((m & mk) == mk)) best = SIZ'(s);
    end
    return best;
  endfunction

  function automatic logic [DAT-1:0] expand(input logic [BEN-1:0] b);
    logic [DAT-1:0] e;
    for (int i = 0; i < BEN; i++) e[8*i +: 8] = {8{b[i]}};
    return e;
  endfunction

  logic [0:0]     state_q;
  logic [BEN-1:0] rem_q;
  logic [BEN-1:0] rem, chunk_ben, rem_next;
  logic [MAX-1:0] off;
  logic [SIZ-1:0] siz;
  logic           last, man_hs, empty_hs, push;
  logic           unused_adr;

  assign unused_adr = ^sub_adr[MAX-1:0];

  assign rem       = (state_q == ST_SPLIT) ? rem_q : sub_ben;
  assign off       = low_idx(rem);
  assign siz       = chunk_siz(rem, off);
  assign chunk_ben = lane_mask(off, siz);
  assign rem_next  = rem & ~chunk_ben;
  assign last      = (rem_next == '0);

  assign man_vld  = sub_vld && (rem != '0) && !rst;
  assign sub_rdy  = sub_vld && !rst && ((rem == '0) || (last && man_rdy));
  assign man_wen  = sub_wen;
  assign man_adr  = {sub_adr[ADR-1:MAX], off};
  assign man_siz  = siz;
  assign man_wdt  = sub_wdt >> {off, 3'b000};

  assign man_hs   = man_vld && man_rdy;
  assign empty_hs = sub_rdy && (rem == '0);
  assign push     = man_hs || empty_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
    end else if (man_hs) begin
      rem_q   <= rem_next;
      state_q <= last ? ST_IDLE : ST_SPLIT;
    end
  end

  // ---- stage p0 .. p[DLY-1]: response tracking pipeline ----
  logic           act_p   [DLY];
  logic           last_p  [DLY];
  logic           first_p [DLY];
  logic           wen_p   [DLY];
  logic [MAX-1:0] off_p   [DLY];
  logic [SIZ-1:0] siz_p   [DLY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DLY; i++) begin
        act_p[i]   <= 1'b0;
        last_p[i]  <= 1'b0;
        first_p[i] <= 1'b0;
      end
    end else begin
      act_p[0]   <= man_hs;
      last_p[0]  <= push && last;
      first_p[0] <= push && (state_q == ST_IDLE);
      for (int i = 1; i < DLY; i++) begin
        act_p[i]   <= act_p[i-1];
        last_p[i]  <= last_p[i-1];
        first_p[i] <= first_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    wen_p[0] <= sub_wen;
    off_p[0] <= off;
    siz_p[0] <= siz;
    for (int i = 1; i < DLY; i++) begin
      wen_p[i] <= wen_p[i-1];
      off_p[i] <= off_p[i-1];
      siz_p[i] <= siz_p[i-1];
    end
  end

  // ---- pipeline output: merge chunk bytes into the reassembly buffer ----
  logic [DAT-1:0] asm_q, base, rsp_data, merged;
  logic           err_q, err_new;

  always_comb begin
    base     = first_p[DLY-1] ? '0 : asm_q;
    rsp_data = (man_rdt & expand(lane_mask('0, siz_p[DLY-1]))) << {off_p[DLY-1], 3'b000};
    merged   = base;
    if (act_p[DLY-1])
      merged = (base & ~expand(lane_mask(off_p[DLY-1], siz_p[DLY-1]))) | rsp_data;
    err_new  = (first_p[DLY-1] ? 1'b0 : err_q) | (act_p[DLY-1] & man_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q <= '0;
      err_q <= 1'b0;
    end else if (act_p[DLY-1] || first_p[DLY-1]) begin
      asm_q <= merged;
      err_q <= err_new;
    end
  end

  assign sub_rdt = (last_p[DLY-1] && !wen_p[DLY-1]) ? merged : '0;
  assign sub_err = last_p[DLY-1] ? err_new : 1'b0;

endmodule

// File: tb/tb_tcb_lib_byteena2logsize.sv
// Randomized bench for tcb_lib_byteena2logsize with a lane-level reference model.
module tb_tcb_lib_byteena2logsize;
  localparam int DAT = 32;
  localparam int ADR = 32;
  localparam int DLY = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        sub_vld, sub_rdy, sub_wen, sub_err;
  logic [31:0] sub_adr, sub_wdt, sub_rdt;
  logic [3:0]  sub_ben;
  logic        man_vld, man_rdy, man_wen, man_err;
  logic [31:0] man_adr, man_wdt, man_rdt;
  logic [1:0]  man_siz;

  always #5 clk = ~clk;

  tcb_lib_byteena2logsize #(.DAT(DAT), .ADR(ADR), .DLY(DLY)) dut (
    .clk(clk), .rst(rst),
    .sub_vld(sub_vld), .sub_rdy(sub_rdy), .sub_wen(sub_wen), .sub_adr(sub_adr),
    .sub_ben(sub_ben), .sub_wdt(sub_wdt), .sub_rdt(sub_rdt), .sub_err(sub_err),
    .man_vld(man_vld), .man_rdy(man_rdy), .man_wen(man_wen), .man_adr(man_adr),
    .man_siz(man_siz), .man_wdt(man_wdt), .man_rdt(man_rdt), .man_err(man_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // expected sub response for the current cycle
  bit          pend = 0;
  logic [31:0] pend_rdt;
  bit          pend_err;

  task automatic check_resp();
    if (pend) begin
      chk("sub_rdt", sub_rdt, pend_rdt);
      chk("sub_err", {31'b0, sub_err}, {31'b0, pend_err});
      pend = 0;
    end
  endtask

  // reference split: lowest enabled byte, then grow the block while the
  // doubled block stays aligned and fully enabled
  int c_n;
  int c_off [4];
  int c_siz [4];

  task automatic split_model(input logic [3:0] ben);
    int r, o, s, w;
    r = int'(ben);
    c_n = 0;
    while (r != 0) begin
      o = 0;
      while (((r >> o) & 1) == 0) o++;
      s = 0;
      while (s < 2) begin
        w = 2 << s;
        if ((o % w) != 0 || ((r >> o) & ((1 << w) - 1)) != ((1 << w) - 1)) break;
        s++;
      end
      c_off[c_n] = o;
      c_siz[c_n] = s;
      c_n++;
      r = r & ~(((1 << (1 << s)) - 1) << o);
    end
  endtask

  // err_mode: 0 random, 1 never, 2 only on the final chunk
  task automatic run_req(input bit wen, input logic [31:0] adr, input logic [3:0] ben,
                         input logic [31:0] wdt, input int err_mode, input bit b2b);
    logic [31:0] exp_rdt, rd;
    bit          exp_err, e;
    int          k, stalls;
    split_model(ben);
    sub_vld = 1'b1; sub_wen = wen; sub_adr = adr; sub_ben = ben; sub_wdt = wdt;
    exp_rdt = '0; exp_err = 1'b0; k = 0; stalls = 0;
    if (c_n == 0) begin
      man_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_resp();
      chk("empty_man_vld", {31'b0, man_vld}, 32'd0);
      chk("empty_sub_rdy", {31'b0, sub_rdy}, 32'd1);
      @(posedge clk); #1;
      man_rdt = $urandom; man_err = 1'($urandom_range(0, 1));
    end
    while (k < c_n) begin
      man_rdy = (stalls >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      check_resp();
      chk("man_vld", {31'b0, man_vld}, 32'd1);
      chk("man_adr", man_adr, (adr & ~32'h3) | 32'(c_off[k]));
      chk("man_siz", {30'b0, man_siz}, 32'(c_siz[k]));
      chk("man_wdt", man_wdt, wdt >> (8 * c_off[k]));
      chk("man_wen", {31'b0, man_wen}, {31'b0, wen});
      chk("sub_rdy", {31'b0, sub_rdy}, {31'b0, man_rdy && (k == c_n - 1)});
      @(posedge clk); #1;
      if (man_rdy) begin
        rd = $urandom;
        e  = (err_mode == 0) ? ($urandom_range(0, 3) == 0) : (err_mode == 2 && k == c_n - 1);
        for (int i = 0; i < (1 << c_siz[k]); i++) exp_rdt[8*(c_off[k]+i) +: 8] = rd[8*i +: 8];
        exp_err = exp_err | e;
        man_rdt = rd; man_err = e;
        k++; stalls = 0;
      end else begin
        man_rdt = $urandom; man_err = 1'($urandom_range(0, 1));
        stalls++;
      end
    end
    pend = 1; pend_rdt = wen ? 32'd0 : exp_rdt; pend_err = exp_err;
    if (!b2b) idle_cycle();
  endtask

  task automatic idle_cycle();
    sub_vld = 1'b0;
    man_rdy = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_resp();
    chk("idle_man_vld", {31'b0, man_vld}, 32'd0);
    chk("idle_sub_rdy", {31'b0, sub_rdy}, 32'd0);
    @(posedge clk); #1;
    man_rdt = $urandom; man_err = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sub_vld = 1'b1; sub_wen = 1'b0; sub_adr = 32'h40; sub_ben = 4'hF; sub_wdt = '0;
    man_rdy = 1'b1; man_rdt = 32'hDEADBEEF; man_err = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_man_vld", {31'b0, man_vld}, 32'd0);
    chk("rst_sub_rdy", {31'b0, sub_rdy}, 32'd0);
    chk("rst_sub_rdt", sub_rdt, 32'd0);
    chk("rst_sub_err", {31'b0, sub_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sub_vld = 1'b0;

    run_req(1'b1, 32'h100, 4'b1111, 32'hAABBCCDD, 1, 1'b0);
    run_req(1'b0, 32'h200, 4'b1011, 32'h0,        1, 1'b0);
    run_req(1'b1, 32'h300, 4'b0110, 32'h00BBCC00, 1, 1'b0);
    run_req(1'b0, 32'h400, 4'b0000, 32'h0,        0, 1'b0);
    run_req(1'b0, 32'h500, 4'b0101, 32'h0,        2, 1'b0);
    run_req(1'b0, 32'h500, 4'b0101, 32'h0,        1, 1'b0);

    // abandon a split after its first chunk
    sub_vld = 1'b1; sub_wen = 1'b0; sub_adr = 32'h200; sub_ben = 4'b1011; man_rdy = 1'b1;
    @(negedge clk);
    chk("mid_man_siz", {30'b0, man_siz}, 32'd1);
    @(posedge clk); #1;
    man_rdt = 32'h5A5A5A5A; man_err = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst_man_vld", {31'b0, man_vld}, 32'd0);
    chk("mid_rst_sub_rdy", {31'b0, sub_rdy}, 32'd0);
    @(negedge clk);
    chk("mid_rst_sub_rdt", sub_rdt, 32'd0);
    chk("mid_rst_sub_err", {31'b0, sub_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_req(1'b0, 32'h600, 4'b1111, 32'h0, 1, 1'b0);

    for (int t = 0; t < 300; t++) begin
      run_req(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), $urandom,
              0, 1'($urandom_range(0, 1)));
    end
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
